pixel_filter_pipe: RTL

//   Streaming per-pixel colour-filter engine for the camera->VGA path; next generation of the filter selector.

---
 rtl/pixel_filter_pkg.sv | 43 ++++
 rtl/pixel_filter_stage.sv | 63 ++++++
 rtl/pixel_filter_pipe.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pixel_filter_pkg.sv
// Shared definitions for the pixel filter pipeline: mode codes, frame states,
// default widths and the grayscale helper.
// Optional feature macro: PIXEL_POSTERIZE_EN (enables mode 10 = posterize).
package pixel_filter_pkg;

    // Default geometry
    localparam int CH_W_DEF      = 4;
    localparam int MODE_W_DEF    = 5;
    localparam int SC_MARGIN_DEF = 3;

    // Filter mode codes (keypad BCD values)
    localparam int MODE_GRAY    = 0;
    localparam int MODE_RED     = 1;
    localparam int MODE_GREEN   = 2;
    localparam int MODE_BLUE    = 3;
    localparam int MODE_CYAN    = 4;
    localparam int MODE_MAGENTA = 5;
    localparam int MODE_YELLOW  = 6;
    localparam int MODE_INVERT  = 7;
    localparam int MODE_EDGE    = 8;
    localparam int MODE_SINCITY = 9;
    localparam int MODE_POSTER  = 10;

    // Frame tracking states
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_IN_FRAME = 1'b1;

    // Channels are zero-extended to this width before the luma sum, so any
    // channel width up to GRAY_IN_W can share the helper.
    localparam int GRAY_IN_W = 16;

    // Y = (R + 2G + B) >> 2; the sum carries two extra bits so it never wraps.
    function automatic logic [GRAY_IN_W-1:0] gray_of(
        input logic [GRAY_IN_W-1:0] r,
        input logic [GRAY_IN_W-1:0] g,
        input logic [GRAY_IN_W-1:0] b
    );
        logic [GRAY_IN_W+1:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum[GRAY_IN_W+1:2];
    endfunction

endpackage

// File: rtl/pixel_filter_stage.sv
// Combinational colour filter for a single {R,G,B} pixel under a given mode.
// Optional feature macro: PIXEL_POSTERIZE_EN (mode 10 keeps the top two bits
// of each channel; otherwise mode 10 is a passthrough).
module pixel_filter_stage
    import pixel_filter_pkg::*;
#(
    parameter int CH_W      = CH_W_DEF,
    parameter int MODE_W    = MODE_W_DEF,
    parameter int SC_MARGIN = SC_MARGIN_DEF
) (
    input  logic [3*CH_W-1:0] pixel_i,
    input  logic [MODE_W-1:0] mode_i,
    output logic [3*CH_W-1:0] pixel_o
);

    localparam logic [CH_W:0] MARGIN = (CH_W+1)'(SC_MARGIN);

    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
    logic [CH_W-1:0] y;
    logic [CH_W-1:0] zero;
    logic            sc_red;

    assign r    = pixel_i[3*CH_W-1 -: CH_W];
    assign g    = pixel_i[2*CH_W-1 -: CH_W];
    assign b    = pixel_i[CH_W-1:0];
    assign zero = '0;
    assign y    = CH_W'(gray_of(GRAY_IN_W'(r), GRAY_IN_W'(g), GRAY_IN_W'(b)));

    // Red dominance test done one bit wider so G/B + margin cannot wrap.
    assign sc_red = ({1'b0, r} >= ({1'b0, g} + MARGIN)) &&
                    ({1'b0, r} >= ({1'b0, b} + MARGIN));

`ifdef PIXEL_POSTERIZE_EN
    logic [3*CH_W-1:0] poster;
    for (genvar gi = 0; gi < 3; gi++) begin : g_poster
        assign poster[gi*CH_W +: CH_W] = {pixel_i[gi*CH_W+CH_W-1 -: 2], {(CH_W-2){1'b0}}};
    end
`endif

    // Select the filtered pixel for the requested mode.
    always_comb begin
        pixel_o = pixel_i;
        case (int'(mode_i))
            MODE_GRAY:    pixel_o = {y, y, y};
            MODE_RED:     pixel_o = {r, zero, zero};
            MODE_GREEN:   pixel_o = {zero, g, zero};
            MODE_BLUE:    pixel_o = {zero, zero, b};
            MODE_CYAN:    pixel_o = {zero, g, b};
            MODE_MAGENTA: pixel_o = {r, zero, b};
            MODE_YELLOW:  pixel_o = {r, g, zero};
            MODE_INVERT:  pixel_o = ~pixel_i;
            MODE_EDGE:    pixel_o = pixel_i;
            MODE_SINCITY: pixel_o = sc_red ? {r, zero, zero} : {y, y, y};
`ifdef PIXEL_POSTERIZE_EN
            MODE_POSTER:  pixel_o = poster;
`endif
            default:      pixel_o = pixel_i;
        endcase
    end

endmodule

// File: rtl/pixel_filter_pipe.sv
// Streaming two-stage colour filter with frame-aligned mode switching.
// Stage 1 registers the accepted pixel together with the mode it must be
// filtered with; stage 2 registers the filtered result onto the output.
// Optional feature macro: PIXEL_POSTERIZE_EN (see pixel_filter_stage).
module pixel_filter_pipe
    import pixel_filter_pkg::*;
#(
    parameter int CH_W      = CH_W_DEF,
    parameter int MODE_W    = MODE_W_DEF,
    parameter int SC_MARGIN = SC_MARGIN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode_in,
    input  logic              mode_valid,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [3*CH_W-1:0] s_pixel,
    input  logic              s_sof,
    input  logic              s_eof,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [3*CH_W-1:0] m_pixel,
    output logic              m_sof,
    output logic              m_eof,
    output logic [MODE_W-1:0] active_mode,
    output logic              mode_pending
);

    localparam int PIX_W = 3*CH_W;

    // Frame / mode control state
    logic [0:0]        state_q,     state_d;
    logic [MODE_W-1:0] active_q,    active_d;
    logic [MODE_W-1:0] pend_mode_q, pend_mode_d;
    logic              pend_q,      pend_d;

    // Stage 1: raw pixel plus the mode captured with it
    logic              v1_q;
    logic [PIX_W-1:0]  pix1_q;
    logic [MODE_W-1:0] mode1_q;
    logic              sof1_q;
    logic              eof1_q;

    // Stage 2: filtered output registers
    logic              m_valid_q;
    logic [PIX_W-1:0]  m_pixel_q;
    logic              m_sof_q;
    logic              m_eof_q;

    logic              en;
    logic              accept;
    logic              apply;
    logic [MODE_W-1:0] beat_mode;
    logic [PIX_W-1:0]  filt_pixel;

    // The whole pipe advances together whenever the output slot is free.
    assign en        = !m_valid_q || m_ready;
    assign s_ready   = en;
    assign accept    = s_valid && en;

    // A pending mode takes effect between frames, or on the sof beat itself;
    // the sof beat then carries the new mode down the pipe.
    assign apply     = pend_q && ((state_q == ST_IDLE) || (accept && s_sof));
    assign beat_mode = apply ? pend_mode_q : active_q;

    // Frame boundary tracking from accepted sof/eof markers.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                if (s_sof && !s_eof) begin
                    state_d = ST_IN_FRAME;
                end
            end else if (s_eof) begin
                state_d = ST_IDLE;
            end
        end
    end

    // Pending-mode bookkeeping: a new strobe always wins over the clear.
    always_comb begin
        active_d    = active_q;
        pend_d      = pend_q;
        pend_mode_d = pend_mode_q;
        if (apply) begin
            active_d = pend_mode_q;
            pend_d   = 1'b0;
        end
        if (mode_valid) begin
            pend_mode_d = mode_in;
            pend_d      = 1'b1;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            active_q    <= '0;
            pend_mode_q <= '0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            pend_mode_q <= pend_mode_d;
            pend_q      <= pend_d;
        end
    end

    pixel_filter_stage #(
        .CH_W      (CH_W),
        .MODE_W    (MODE_W),
        .SC_MARGIN (SC_MARGIN)
    ) u_stage (
        .pixel_i (pix1_q),
        .mode_i  (mode1_q),
        .pixel_o (filt_pixel)
    );

    // Two-stage data pipe, frozen while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            pix1_q    <= '0;
            mode1_q   <= '0;
            sof1_q    <= 1'b0;
            eof1_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_pixel_q <= '0;
            m_sof_q   <= 1'b0;
            m_eof_q   <= 1'b0;
        end else if (en) begin
            v1_q      <= s_valid;
            pix1_q    <= s_pixel;
            mode1_q   <= beat_mode;
            sof1_q    <= s_sof;
            eof1_q    <= s_eof;
            m_valid_q <= v1_q;
            m_pixel_q <= filt_pixel;
            m_sof_q   <= sof1_q;
            m_eof_q   <= eof1_q;
        end
    end

    assign m_valid      = m_valid_q;
    assign m_pixel      = m_pixel_q;
    assign m_sof        = m_sof_q;
    assign m_eof        = m_eof_q;
    assign active_mode  = active_q;
    assign mode_pending = pend_q;

endmodule
